// File: rtl/solicitud_peaton.sv
// Pedestrian push-button front end: sync, debounce,
// request/ack handshake with hold-off and one-press memory.
module solicitud_peaton #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter int HOLDOFF_CYCLES  = 20,
  parameter int COUNT_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_raw,
  input  logic               ack,
  output logic               req,
  output logic               pending,
  output logic               btn_clean,
  output logic               press_pulse,
  output logic               busy,
  output logic [COUNT_W-1:0] served_count
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ?
                      $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (HOLDOFF_CYCLES > 1) ?
                      $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HO_LAST = HW'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLDOFF
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_sync;
  logic [DW-1:0]          db_cnt;
  logic [HW-1:0]          ho_cnt;
  state_t                 state;

  assign btn_sync = sync_q[SYNC_STAGES-1];

  // Shift the raw button through the synchroniser chain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw};
    end
  end

  // Toggle btn_clean after enough consecutive differing samples
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt      <= '0;
      btn_clean   <= 1'b0;
      press_pulse <= 1'b0;
    end else begin
      press_pulse <= 1'b0;
      if (btn_sync == btn_clean) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_cnt      <= '0;
        btn_clean   <= btn_sync;
        press_pulse <= btn_sync;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Request / hold-off state machine with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      req          <= 1'b0;
      busy         <= 1'b0;
      pending      <= 1'b0;
      ho_cnt       <= '0;
      served_count <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (press_pulse) begin
            state <= REQ;
            req   <= 1'b1;
            busy  <= 1'b1;
          end
        end
        REQ: begin
          if (ack) begin
            state  <= HOLDOFF;
            req    <= 1'b0;
            ho_cnt <= HO_LAST;
            if (served_count != '1) begin
              served_count <= served_count + 1'b1;
            end
            if (press_pulse) begin
              pending <= 1'b1;
            end
          end
        end
        HOLDOFF: begin
          if (ho_cnt == '0) begin
            pending <= 1'b0;
            if (pending || press_pulse) begin
              state <= REQ;
              req   <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            ho_cnt <= ho_cnt - 1'b1;
            if (press_pulse) begin
              pending <= 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          req     <= 1'b0;
          busy    <= 1'b0;
          pending <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_solicitud_peaton.sv
// Self-checking bench for solicitud_peaton against a
// behavioural model driven by directed and random stimulus.
module tb_solicitud_peaton;

  localparam int S  = 2;
  localparam int D  = 8;
  localparam int H  = 20;
  localparam int CW = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          btn_raw;
  logic          ack;
  logic          req;
  logic          pending;
  logic          btn_clean;
  logic          press_pulse;
  logic          busy;
  logic [CW-1:0] served_count;

  int n_cmp;
  int n_bad;

  // model state
  logic rq[$];
  logic sq[$];
  logic m_clean;
  logic m_pp;
  logic m_req;
  logic m_pend;
  int   m_hold;
  int   m_served;

  solicitud_peaton #(
    .SYNC_STAGES(S),
    .DEBOUNCE_CYCLES(D),
    .HOLDOFF_CYCLES(H),
    .COUNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_raw(btn_raw),
    .ack(ack),
    .req(req),
    .pending(pending),
    .btn_clean(btn_clean),
    .press_pulse(press_pulse),
    .busy(busy),
    .served_count(served_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    sq.delete();
    m_clean  = 1'b0;
    m_pp     = 1'b0;
    m_req    = 1'b0;
    m_pend   = 1'b0;
    m_hold   = 0;
    m_served = 0;
  endtask

  // One clock edge of the specified behaviour.
  task automatic model_edge(input logic r, input logic a);
    logic bs;
    logic tog;
    logic pp_new;
    bs = (rq.size() >= S) ? rq[rq.size() - S] : 1'b0;
    rq.push_back(r);
    if (rq.size() > 8) void'(rq.pop_front());
    // clean level flips once D consecutive synced samples disagree
    sq.push_back(bs);
    if (sq.size() > D) void'(sq.pop_front());
    tog = (sq.size() == D);
    foreach (sq[i]) if (sq[i] == m_clean) tog = 1'b0;
    if (tog) begin
      m_clean = ~m_clean;
      sq.delete();
    end
    pp_new = tog && m_clean;
    if (m_hold > 0) begin
      if (m_pp) m_pend = 1'b1;
      m_hold--;
      if (m_hold == 0 && m_pend) begin
        m_req  = 1'b1;
        m_pend = 1'b0;
      end
    end else if (m_req) begin
      if (a) begin
        m_req  = 1'b0;
        m_hold = H;
        if (m_served < CMAX) m_served++;
        if (m_pp) m_pend = 1'b1;
      end
    end else if (m_pp) begin
      m_req = 1'b1;
    end
    m_pp = pp_new;
  endtask

  task automatic check_all();
    chk("req", 32'(req), 32'(m_req));
    chk("pending", 32'(pending), 32'(m_pend));
    chk("btn_clean", 32'(btn_clean), 32'(m_clean));
    chk("press_pulse", 32'(press_pulse), 32'(m_pp));
    chk("busy", 32'(busy), 32'(m_req || m_hold > 0));
    chk("served_count", 32'(served_count), 32'(m_served));
  endtask

  task automatic step(input logic r, input logic b,
                      input logic a);
    rst     = r;
    btn_raw = b;
    ack     = a;
    if (!r) model_reset();
    @(posedge clk);
    #1;
    if (r) model_edge(b, a);
    else model_reset();
    check_all();
  endtask

  initial begin
    int first_edge;
    int lvl;
    int hold;
    int pulses;
    int guard;
    n_cmp   = 0;
    n_bad   = 0;
    rst     = 1'b0;
    btn_raw = 1'b1;
    ack     = 1'b1;
    model_reset();

    // reset with active inputs
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);

    // stable press after reset release
    first_edge = -1;
    for (int i = 1; i <= 14; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (first_edge < 0 && btn_clean) first_edge = i;
    end
    chk("clean_latency", 32'(first_edge), 32'd10);
    chk("req_after_press", 32'(req), 32'd1);

    // long wait, then single ack
    for (int i = 0; i < 50; i++) begin
      step(1'b1, 1'b0, 1'b0);
      if (i == 49) chk("req_held", 32'(req), 32'd1);
    end
    step(1'b1, 1'b0, 1'b1);
    chk("req_drop", 32'(req), 32'd0);
    chk("served_one", 32'(served_count), 32'd1);
    for (int i = 0; i < 22; i++) step(1'b1, 1'b0, 1'b0);
    chk("idle_after_hold", 32'(busy), 32'd0);

    // bouncing button, then stable press
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'(((i / 3) % 2) == 0), 1'b0);
      if (press_pulse) pulses++;
    end
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b1, 1'b0);
      if (press_pulse) pulses++;
    end
    chk("bounce_pulses", 32'(pulses), 32'd1);
    for (int i = 0; i < 15; i++) step(1'b1, 1'b0, 1'b0);

    // ack held several cycles counts once
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    chk("held_ack", 32'(served_count), 32'd2);

    // random presses, glitches and acks
    lvl = 0;
    for (int n = 0; n < 3000; ) begin
      hold = (($urandom_range(0, 3) == 0)) ?
             $urandom_range(1, 6) : $urandom_range(8, 40);
      lvl  = 1 - lvl;
      for (int k = 0; k < hold; k++) begin
        step(1'b1, 1'(lvl), 1'($urandom_range(0, 11) == 0));
        n++;
      end
    end

    // async reset while a request is raised
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b0);
    guard = 0;
    while (!m_req && guard < 300) begin
      step(1'b1, 1'b1, 1'b0);
      guard++;
    end
    chk("reach_req", 32'(m_req), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("async_req", 32'(req), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b0, 1'b0);
    chk("no_pending_kept", 32'(pending), 32'd0);
    chk("no_req_kept", 32'(req), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
